// File: rtl/vga_timing_out.sv
// 640x480@60 VGA raster generator: pixel-tick divider, h/v counters and registered RGB/HS/VS pins.
// Optional build macro VGA_TEST_PATTERN_EN replaces the renderer colour with an 8-bar test pattern.
module vga_timing_out #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] pix_r,
  input  logic [3:0] pix_g,
  input  logic [3:0] pix_b,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_tick,
  output logic       frame_start,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_err
    $error("vga_timing_out: H_TOTAL/V_TOTAL do not fit the 10-bit counters");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic [3:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             tick;
  logic             in_active;
  logic [3:0]       col_r, col_g, col_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0] bar_full;
  logic [2:0] bar;
  logic       unused_pix;

  assign bar_full   = hcount_q / BAR_W;
  assign bar        = bar_full[2:0];
  assign col_r      = {4{bar[2]}};
  assign col_g      = {4{bar[1]}};
  assign col_b      = {4{bar[0]}};
  assign unused_pix = ^{pix_r, pix_g, pix_b, bar_full[9:3]};
`else
  assign col_r = pix_r;
  assign col_g = pix_g;
  assign col_b = pix_b;
`endif

  // A tick is never reported while reset is held, even though reset only clears state.
  assign tick      = enable && !reset && (div_q == DIV_LAST);
  assign in_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);

  always_comb begin
    div_d    = div_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      // Pins take the values of the pixel being left, so sync and colour stay aligned.
      hs_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vs_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      r_d  = in_active ? col_r : 4'h0;
      g_d  = in_active ? col_g : 4'h0;
      b_d  = in_active ? col_b : 4'h0;
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign pix_tick    = tick;
  assign frame_start = tick && (hcount_q == '0) && (vcount_q == '0);
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a full-size instance plus a shrunken-raster instance, both checked
// every cycle against a tick-count reference model, with table vectors and hand sequences.
module tb_vga_timing_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] pr, pg, pb;

  logic [9:0] hc0, vc0, hc1, vc1;
  logic       tk0, fs0, tk1, fs1, hs0, vs0, hs1, vs1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  always #5 clk = ~clk;

  vga_timing_out u_main (
    .CLK100MHZ(clk), .reset(rst), .enable(en),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .hcount(hc0), .vcount(vc0), .pix_tick(tk0), .frame_start(fs0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0)
  );

  vga_timing_out #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .CLK100MHZ(clk), .reset(rst), .enable(en),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .hcount(hc1), .vcount(vc1), .pix_tick(tk1), .frame_start(fs1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1)
  );

  int errors = 0;
  int checks = 0;

  // Per-instance raster geometry.
  function automatic int p_cd(int d);  return d ? 3  : 4;   endfunction
  function automatic int p_ha(int d);  return d ? 16 : 640; endfunction
  function automatic int p_hfp(int d); return d ? 2  : 16;  endfunction
  function automatic int p_hs(int d);  return d ? 3  : 96;  endfunction
  function automatic int p_ht(int d);  return d ? 24 : 800; endfunction
  function automatic int p_va(int d);  return d ? 6  : 480; endfunction
  function automatic int p_vfp(int d); return d ? 2  : 10;  endfunction
  function automatic int p_vs(int d);  return d ? 2  : 2;   endfunction
  function automatic int p_vt(int d);  return d ? 12 : 525; endfunction

  // Model: everything follows from the number of enabled clock edges since reset.
  longint     ecnt  [2];
  logic [11:0] e_rgb [2];
  logic       e_hs  [2];
  logic       e_vs  [2];
  logic       last_tk0, last_fs1;

  function automatic logic [11:0] colour(int d, int h, logic [11:0] pix);
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    bar = 3'(h / (p_ha(d) / 8));
    return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
    return pix;
`endif
  endfunction

  function automatic int exp_h(int d);
    return int'((ecnt[d] / p_cd(d)) % p_ht(d));
  endfunction
  function automatic int exp_v(int d);
    return int'((ecnt[d] / p_cd(d) / p_ht(d)) % p_vt(d));
  endfunction
  function automatic logic exp_tick(int d);
    return en && !rst && ((ecnt[d] % p_cd(d)) == p_cd(d) - 1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0; e_rgb[d] = 12'h000; e_hs[d] = 1'b1; e_vs[d] = 1'b1;
    end
  endtask

  task automatic model_edge();
    int h, v, hf, vf;
    if (rst) begin
      model_reset();
    end else if (en) begin
      for (int d = 0; d < 2; d++) begin
        if ((ecnt[d] % p_cd(d)) == p_cd(d) - 1) begin
          h = exp_h(d); v = exp_v(d);
          hf = p_ha(d) + p_hfp(d);
          vf = p_va(d) + p_vfp(d);
          e_hs[d]  = !(h >= hf && h < hf + p_hs(d));
          e_vs[d]  = !(v >= vf && v < vf + p_vs(d));
          e_rgb[d] = (h < p_ha(d) && v < p_va(d)) ? colour(d, h, {pr, pg, pb}) : 12'h000;
        end
        ecnt[d]++;
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_comb();
    chk("m_pix_tick", 32'(tk0), 32'(exp_tick(0)));
    chk("s_pix_tick", 32'(tk1), 32'(exp_tick(1)));
    chk("m_frame_start", 32'(fs0), 32'(exp_tick(0) && exp_h(0) == 0 && exp_v(0) == 0));
    chk("s_frame_start", 32'(fs1), 32'(exp_tick(1) && exp_h(1) == 0 && exp_v(1) == 0));
  endtask

  task automatic check_state();
    chk("m_hcount", 32'(hc0), 32'(exp_h(0)));
    chk("m_vcount", 32'(vc0), 32'(exp_v(0)));
    chk("m_rgb", 32'({r0, g0, b0}), 32'(e_rgb[0]));
    chk("m_hs", 32'(hs0), 32'(e_hs[0]));
    chk("m_vs", 32'(vs0), 32'(e_vs[0]));
    chk("s_hcount", 32'(hc1), 32'(exp_h(1)));
    chk("s_vcount", 32'(vc1), 32'(exp_v(1)));
    chk("s_rgb", 32'({r1, g1, b1}), 32'(e_rgb[1]));
    chk("s_hs", 32'(hs1), 32'(e_hs[1]));
    chk("s_vs", 32'(vs1), 32'(e_vs[1]));
  endtask

  // One clock: apply inputs, check strobes, take the edge, check registered state.
  task automatic cyc(input logic e, input logic [11:0] pix);
    en = e;
    {pr, pg, pb} = pix;
    #1;
    check_comb();
    last_tk0 = tk0;
    last_fs1 = fs1;
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  function automatic logic [11:0] rpix();
    return 12'($urandom);
  endfunction

  typedef struct {
    int          h;
    int          v;
    logic [11:0] pix;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   bound;
    int   sh, sv, prev_t, prev_f;
    logic [11:0] srgb;
    logic shs, svs;

`ifdef VGA_TEST_PATTERN_EN
    tbl.push_back('{0,   0, 12'h7E1, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{80,  0, 12'h123, 12'h00F, 1'b1, 1'b1});
    tbl.push_back('{560, 0, 12'h000, 12'hFFF, 1'b1, 1'b1});
    tbl.push_back('{656, 0, 12'hFFF, 12'h000, 1'b0, 1'b1});
    tbl.push_back('{752, 0, 12'hFFF, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{0,   1, 12'hFFF, 12'h000, 1'b1, 1'b1});
`else
    tbl.push_back('{0,   0, 12'h7E1, 12'h7E1, 1'b1, 1'b1});
    tbl.push_back('{639, 0, 12'hFFF, 12'hFFF, 1'b1, 1'b1});
    tbl.push_back('{640, 0, 12'hFFF, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{655, 0, 12'hABC, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{656, 0, 12'hABC, 12'h000, 1'b0, 1'b1});
    tbl.push_back('{751, 0, 12'hFFF, 12'h000, 1'b0, 1'b1});
    tbl.push_back('{752, 0, 12'hFFF, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{799, 0, 12'hFFF, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{0,   1, 12'h5A3, 12'h5A3, 1'b1, 1'b1});
    tbl.push_back('{7,   1, 12'hC3E, 12'hC3E, 1'b1, 1'b1});
`endif

    // Reset held with enable high: no ticks, counters and pins at rest.
    rst = 1'b0; en = 1'b1; {pr, pg, pb} = 12'h000;
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, rpix());
    chk("rst_hcount", 32'(hc0), 0);
    chk("rst_vcount", 32'(vc0), 0);
    chk("rst_hs", 32'(hs0), 1);
    chk("rst_vs", 32'(vs0), 1);
    chk("rst_rgb", 32'({r0, g0, b0}), 0);
    rst = 1'b0;

    // Table vectors: reach the pixel, hold its colour until it is ticked, check the pins.
    foreach (tbl[k]) begin
      bound = 0;
      while (!(hc0 == 10'(tbl[k].h) && vc0 == 10'(tbl[k].v)) && bound < 4000) begin
        cyc(1'b1, rpix());
        bound++;
      end
      chk("tbl_reach_h", 32'(hc0), 32'(tbl[k].h));
      bound = 0;
      while (hc0 == 10'(tbl[k].h) && vc0 == 10'(tbl[k].v) && bound < 8) begin
        cyc(1'b1, tbl[k].pix);
        bound++;
      end
      chk("tbl_rgb", 32'({r0, g0, b0}), 32'(tbl[k].rgb));
      chk("tbl_hs", 32'(hs0), 32'(tbl[k].hs));
      chk("tbl_vs", 32'(vs0), 32'(tbl[k].vs));
    end

    // Random enable and colour until the main raster sits at (300,10).
    bound = 0;
    while (!(hc0 == 10'd300 && vc0 == 10'd10) && bound < 60000) begin
      cyc(($urandom % 10) != 0, rpix());
      bound++;
    end
    chk("reach_300_10_h", 32'(hc0), 300);
    chk("reach_300_10_v", 32'(vc0), 10);

    // Freeze for 50 cycles, then the next tick must land on 301.
    sh = hc0; sv = vc0; srgb = {r0, g0, b0}; shs = hs0; svs = vs0;
    for (int i = 0; i < 50; i++) cyc(1'b0, rpix());
    chk("frz_hcount", 32'(hc0), 32'(sh));
    chk("frz_vcount", 32'(vc0), 32'(sv));
    chk("frz_rgb", 32'({r0, g0, b0}), 32'(srgb));
    chk("frz_hs", 32'(hs0), 32'(shs));
    chk("frz_vs", 32'(vs0), 32'(svs));
    bound = 0;
    while (hc0 == 10'd300 && bound < 8) begin
      cyc(1'b1, rpix());
      bound++;
    end
    chk("resume_hcount", 32'(hc0), 301);
    chk("resume_vcount", 32'(vc0), 10);

    // Mid-frame reset takes effect without waiting for a clock edge.
    rst = 1'b1;
    #2;
    chk("async_hcount", 32'(hc0), 0);
    chk("async_vcount", 32'(vc0), 0);
    chk("async_hs", 32'(hs0), 1);
    chk("async_vs", 32'(vs0), 1);
    chk("async_rgb", 32'({r0, g0, b0}), 0);
    model_reset();
    cyc(1'b1, rpix());
    cyc(1'b1, rpix());
    rst = 1'b0;

    // Tick spacing, 100 pixels in 400 clocks, and small-raster frame period (24*12*3 clocks).
    prev_t = -1; prev_f = -1;
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1, rpix());
      if (last_tk0 && i < 400) begin
        if (prev_t >= 0) chk("tick_period", 32'(i - prev_t), 4);
        prev_t = i;
      end
      if (last_fs1) begin
        if (prev_f >= 0) chk("frame_period", 32'(i - prev_f), 864);
        prev_f = i;
      end
      if (i == 399) begin
        chk("hcount_after_400", 32'(hc0), 100);
        chk("vcount_after_400", 32'(vc0), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
